// File: rtl/bp_me_pkg.sv
// -----------------------------------------------------------------------------
// bp_me_pkg
// Shared types and constants for the CCE memory-channel arbiter.
//   - bp_me_cce_mem_arb_state_e : arbiter FSM states
//   - bp_me_cce_mem_arb_stat_width_gp : width of the optional statistics counters
//   - bp_me_cce_mem_msg_width_default_gp : default full message width
//   - bp_me_safe_clog2() : clog2 that never returns 0 (1-entry structures still
//     need a 1-bit index)
// -----------------------------------------------------------------------------
package bp_me_pkg;

  typedef enum logic [1:0] {
    e_reset = 2'd0,
    e_ready = 2'd1,
    e_send  = 2'd2
  } bp_me_cce_mem_arb_state_e;

  localparam int bp_me_cce_mem_arb_stat_width_gp = 32;

  // Header plus one cache block; integrations override msg_width_p with the
  // cce_mem_msg_width_lp of their own configuration.
  localparam int bp_me_cce_mem_msg_width_default_gp = 576;

  function automatic int bp_me_safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bp_me_cce_mem_arb_order_fifo.sv
// -----------------------------------------------------------------------------
// bp_me_cce_mem_arb_order_fifo
// Small circular FIFO holding the client index of every command sent to
// memory, so in-order responses can be steered back to their owner.
//
// Ports:
//   clk_i, reset_i    : clock, asynchronous active-high reset
//   data_i, v_i       : push side; a push happens on v_i & ready_o
//   ready_o           : space available (a same-cycle pop also frees a slot)
//   data_o, v_o       : head entry and its valid
//   yumi_i            : pop the head; only asserted while v_o is high
//   full_o, empty_o   : occupancy flags
// -----------------------------------------------------------------------------
module bp_me_cce_mem_arb_order_fifo
  import bp_me_pkg::*;
  #(parameter int els_p   = 8
  , parameter int width_p = 2
  )
  (input  logic               clk_i
  , input  logic               reset_i
  , input  logic [width_p-1:0] data_i
  , input  logic               v_i
  , output logic               ready_o
  , output logic [width_p-1:0] data_o
  , output logic               v_o
  , input  logic               yumi_i
  , output logic               full_o
  , output logic               empty_o
  );

  localparam int ptr_width_lp = bp_me_safe_clog2(els_p);

  logic [width_p-1:0]      mem_r [els_p];
  logic [ptr_width_lp-1:0] rptr_r, wptr_r;
  logic [ptr_width_lp:0]   count_r;
  logic                    enq, deq;

  assign full_o  = (count_r == (ptr_width_lp+1)'(els_p));
  assign empty_o = (count_r == '0);
  assign v_o     = ~empty_o;
  assign data_o  = mem_r[rptr_r];

  // A pop in the same cycle frees the slot the push will use, so a full FIFO
  // can still accept when the head is leaving.
  assign ready_o = ~full_o | yumi_i;
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(els_p-1)) ? '0 : p + 1'b1;
  endfunction

  // Storage is not reset: entries are only read while counted as occupied.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_r[wptr_r] <= data_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq) wptr_r <= ptr_inc(wptr_r);
      if (deq) rptr_r <= ptr_inc(rptr_r);
      case ({enq, deq})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/bp_me_cce_mem_arbiter.sv
// -----------------------------------------------------------------------------
// bp_me_cce_mem_arbiter
// Shares one CCE memory command/response channel among num_clients_p
// requesters. Commands are round-robin arbitrated, registered, and sent to
// memory one at a time; the winner's index goes into an order FIFO so each
// in-order memory response is steered back to the client that issued it.
//
// Ports:
//   clk_i, reset_i        : clock, asynchronous active-high reset
//   client_cmd_i/_v_i     : per-client command message and valid
//   client_cmd_yumi_o     : per-client consume strobe (at most one bit set)
//   client_resp_o         : response message, broadcast to all clients
//   client_resp_v_o       : one-hot response valid toward the owner
//   client_resp_ready_i   : per-client response ready
//   mem_cmd_o/_v_o        : registered command toward memory and its valid
//   mem_cmd_yumi_i        : memory consumed the command
//   mem_resp_i/_v_i       : memory response and valid
//   mem_resp_ready_o      : arbiter can accept the response
//   idle_o                : ready state with no responses outstanding
//
// Optional feature (macro BP_ME_CCE_MEM_ARB_STATS_EN):
//   stat_grant_o      : saturating per-client grant counters
//   stat_full_stall_o : cycles a valid request was blocked by a full FIFO
// -----------------------------------------------------------------------------
module bp_me_cce_mem_arbiter
  import bp_me_pkg::*;
  #(parameter int num_clients_p     = 4
  , parameter int msg_width_p       = bp_me_cce_mem_msg_width_default_gp
  , parameter int max_outstanding_p = 8
  , localparam int lg_clients_lp    = bp_me_safe_clog2(num_clients_p)
  )
  (input  logic                                clk_i
  , input  logic                                reset_i
  , input  logic [num_clients_p*msg_width_p-1:0] client_cmd_i
  , input  logic [num_clients_p-1:0]             client_cmd_v_i
  , output logic [num_clients_p-1:0]             client_cmd_yumi_o
  , output logic [msg_width_p-1:0]               client_resp_o
  , output logic [num_clients_p-1:0]             client_resp_v_o
  , input  logic [num_clients_p-1:0]             client_resp_ready_i
  , output logic [msg_width_p-1:0]               mem_cmd_o
  , output logic                                 mem_cmd_v_o
  , input  logic                                 mem_cmd_yumi_i
  , input  logic [msg_width_p-1:0]               mem_resp_i
  , input  logic                                 mem_resp_v_i
  , output logic                                 mem_resp_ready_o
  , output logic                                 idle_o
`ifdef BP_ME_CCE_MEM_ARB_STATS_EN
  , output logic [num_clients_p*bp_me_cce_mem_arb_stat_width_gp-1:0] stat_grant_o
  , output logic [bp_me_cce_mem_arb_stat_width_gp-1:0]               stat_full_stall_o
`endif
  );

  bp_me_cce_mem_arb_state_e state_r, state_n;

  logic [msg_width_p-1:0]   cmd_r;
  logic [lg_clients_lp-1:0] tag_r;
  logic [lg_clients_lp-1:0] ptr_r;

  logic                     grant_found;
  logic [num_clients_p-1:0] grant_oh;
  logic [lg_clients_lp-1:0] grant_idx;
  logic [msg_width_p-1:0]   grant_cmd;
  logic                     grant_take;

  logic                     fifo_push, fifo_pop, fifo_ready;
  logic                     fifo_v, fifo_full, fifo_empty;
  logic [lg_clients_lp-1:0] fifo_tag;
  logic                     head_ready;

  // ---------------------------------------------------------------------------
  // Round-robin search: first valid client at or after the pointer, wrapping.
  // ---------------------------------------------------------------------------
  function automatic int rr_idx(input logic [lg_clients_lp-1:0] base, input int off);
    return (int'(base) + off) % num_clients_p;
  endfunction

  always_comb begin
    grant_found = 1'b0;
    grant_oh    = '0;
    grant_idx   = '0;
    for (int i = 0; i < num_clients_p; i++) begin
      if (!grant_found && client_cmd_v_i[rr_idx(ptr_r, i)]) begin
        grant_found                 = 1'b1;
        grant_oh[rr_idx(ptr_r, i)]  = 1'b1;
        grant_idx                   = lg_clients_lp'(rr_idx(ptr_r, i));
      end
    end
  end

  always_comb begin
    grant_cmd = '0;
    for (int i = 0; i < num_clients_p; i++) begin
      if (grant_oh[i]) begin
        grant_cmd = client_cmd_i[i*msg_width_p +: msg_width_p];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and per-state strobes.
  // fifo_ready already accounts for a response popping this cycle, so a client
  // can win the slot that the departing response frees.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n           = state_r;
    grant_take        = 1'b0;
    fifo_push         = 1'b0;
    client_cmd_yumi_o = '0;
    case (state_r)
      e_reset: state_n = e_ready;
      e_ready: begin
        if (grant_found && fifo_ready) begin
          grant_take        = 1'b1;
          client_cmd_yumi_o = grant_oh;
          state_n           = e_send;
        end
      end
      e_send: begin
        // Every command gets a response, so every accepted command is tracked.
        if (mem_cmd_yumi_i) begin
          fifo_push = 1'b1;
          state_n   = e_ready;
        end
      end
      default: state_n = e_reset;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= e_reset;
      cmd_r   <= '0;
      tag_r   <= '0;
    end else begin
      state_r <= state_n;
      if (grant_take) begin
        cmd_r <= grant_cmd;
        tag_r <= grant_idx;
      end
    end
  end

  generate
    if (num_clients_p == 1) begin : g_single_ptr
      assign ptr_r = '0;
    end else begin : g_rr_ptr
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          ptr_r <= '0;
        end else if (grant_take) begin
          ptr_r <= (grant_idx == lg_clients_lp'(num_clients_p-1)) ? '0 : grant_idx + 1'b1;
        end
      end
    end
  endgenerate

  assign mem_cmd_o   = cmd_r;
  assign mem_cmd_v_o = (state_r == e_send);
  assign idle_o      = (state_r == e_ready) & fifo_empty;

  // ---------------------------------------------------------------------------
  // Order FIFO and response steering (purely combinational on the way back).
  // ---------------------------------------------------------------------------
  bp_me_cce_mem_arb_order_fifo
    #(.els_p(max_outstanding_p)
    , .width_p(lg_clients_lp)
    )
    order_fifo
    (.clk_i   (clk_i)
    , .reset_i (reset_i)
    , .data_i  (tag_r)
    , .v_i     (fifo_push)
    , .ready_o (fifo_ready)
    , .data_o  (fifo_tag)
    , .v_o     (fifo_v)
    , .yumi_i  (fifo_pop)
    , .full_o  (fifo_full)
    , .empty_o (fifo_empty)
    );

  always_comb begin
    client_resp_v_o = '0;
    head_ready      = 1'b0;
    for (int i = 0; i < num_clients_p; i++) begin
      if (fifo_tag == lg_clients_lp'(i)) begin
        client_resp_v_o[i] = mem_resp_v_i & fifo_v;
        head_ready         = client_resp_ready_i[i];
      end
    end
  end

  assign client_resp_o    = mem_resp_i;
  assign mem_resp_ready_o = fifo_v & head_ready;
  assign fifo_pop         = mem_resp_v_i & mem_resp_ready_o;

  // A response with nothing outstanding has no owner; it is never accepted.
  resp_without_cmd_a: assert property (@(posedge clk_i) disable iff (reset_i)
    !(mem_resp_v_i && !fifo_v));

  // ---------------------------------------------------------------------------
  // Optional statistics.
  // ---------------------------------------------------------------------------
`ifdef BP_ME_CCE_MEM_ARB_STATS_EN
  localparam int sw_lp = bp_me_cce_mem_arb_stat_width_gp;

  logic [sw_lp-1:0] stall_cnt_r;
  logic             full_stall;

  genvar gi;
  generate
    for (gi = 0; gi < num_clients_p; gi++) begin : g_grant_cnt
      logic [sw_lp-1:0] grant_cnt_r;
      always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
          grant_cnt_r <= '0;
        end else if (client_cmd_yumi_o[gi] && (grant_cnt_r != '1)) begin
          grant_cnt_r <= grant_cnt_r + 1'b1;
        end
      end
      assign stat_grant_o[gi*sw_lp +: sw_lp] = grant_cnt_r;
    end
  endgenerate

  assign full_stall = (state_r == e_ready) & (|client_cmd_v_i) & ~fifo_ready;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stall_cnt_r <= '0;
    end else if (full_stall && (stall_cnt_r != '1)) begin
      stall_cnt_r <= stall_cnt_r + 1'b1;
    end
  end

  assign stat_full_stall_o = stall_cnt_r;
`endif

  // fifo_full is kept for debug visibility; it folds into fifo_ready.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_bp_me_cce_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bp_me_cce_mem_arbiter
// Directed scenarios followed by a randomized phase. A transaction-level
// reference (round-robin pointer, single command slot, queue of outstanding
// owners) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_bp_me_cce_mem_arbiter;

  localparam int NC = 4;
  localparam int MW = 32;
  localparam int MO = 8;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic [NC*MW-1:0] client_cmd_i;
  logic [NC-1:0]   client_cmd_v_i;
  logic [NC-1:0]   client_cmd_yumi_o;
  logic [MW-1:0]   client_resp_o;
  logic [NC-1:0]   client_resp_v_o;
  logic [NC-1:0]   client_resp_ready_i;
  logic [MW-1:0]   mem_cmd_o;
  logic            mem_cmd_v_o;
  logic            mem_cmd_yumi_i;
  logic [MW-1:0]   mem_resp_i;
  logic            mem_resp_v_i;
  logic            mem_resp_ready_o;
  logic            idle_o;

  logic [MW-1:0]   cmd_data [NC];

  always_comb begin
    client_cmd_i = '0;
    for (int i = 0; i < NC; i++) client_cmd_i[i*MW +: MW] = cmd_data[i];
  end

  always #5 clk_i = ~clk_i;

  bp_me_cce_mem_arbiter #(.num_clients_p(NC), .msg_width_p(MW), .max_outstanding_p(MO)) dut (
    .clk_i               (clk_i),
    .reset_i             (reset_i),
    .client_cmd_i        (client_cmd_i),
    .client_cmd_v_i      (client_cmd_v_i),
    .client_cmd_yumi_o   (client_cmd_yumi_o),
    .client_resp_o       (client_resp_o),
    .client_resp_v_o     (client_resp_v_o),
    .client_resp_ready_i (client_resp_ready_i),
    .mem_cmd_o           (mem_cmd_o),
    .mem_cmd_v_o         (mem_cmd_v_o),
    .mem_cmd_yumi_i      (mem_cmd_yumi_i),
    .mem_resp_i          (mem_resp_i),
    .mem_resp_v_i        (mem_resp_v_i),
    .mem_resp_ready_o    (mem_resp_ready_o),
    .idle_o              (idle_o)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state
  int          m_q[$];
  bit          m_busy;
  bit          m_warm;
  int          m_ptr;
  int          m_tag;
  logic [MW-1:0] m_cmd;

  // Last sampled outputs, for scenario-specific checks against constants
  logic [NC-1:0] obs_yumi, obs_resp_v;
  logic          obs_cmd_v, obs_resp_ready, obs_idle;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_busy = 1'b0;
    m_warm = 1'b0;
    m_ptr  = 0;
    m_tag  = 0;
    m_cmd  = '0;
  endtask

  // One clock: inputs are already driven; check at the falling edge, then
  // advance the reference at the rising edge.
  task automatic cycle();
    int            g;
    bit            grant, pop, e_rr;
    logic [NC-1:0] e_yumi, e_rv;
    @(negedge clk_i);
    e_rr = (m_q.size() > 0) && client_resp_ready_i[m_q[0]];
    pop  = mem_resp_v_i && e_rr;
    e_rv = '0;
    if (mem_resp_v_i && m_q.size() > 0) e_rv[m_q[0]] = 1'b1;
    g = -1;
    for (int k = 0; k < NC; k++)
      if (g < 0 && client_cmd_v_i[(m_ptr + k) % NC]) g = (m_ptr + k) % NC;
    grant  = m_warm && !m_busy && (g >= 0) && (m_q.size() < MO || pop);
    e_yumi = '0;
    if (grant) e_yumi[g] = 1'b1;
    chk("yumi",           32'(client_cmd_yumi_o), 32'(e_yumi));
    chk("mem_cmd_v",      32'(mem_cmd_v_o),       32'(m_busy));
    chk("mem_cmd",        mem_cmd_o,              m_cmd);
    chk("resp_v",         32'(client_resp_v_o),   32'(e_rv));
    chk("mem_resp_ready", 32'(mem_resp_ready_o),  32'(e_rr));
    chk("resp_data",      client_resp_o,          mem_resp_i);
    chk("idle",           32'(idle_o),            32'(m_warm && !m_busy && m_q.size() == 0));
    obs_yumi       = client_cmd_yumi_o;
    obs_resp_v     = client_resp_v_o;
    obs_cmd_v      = mem_cmd_v_o;
    obs_resp_ready = mem_resp_ready_o;
    obs_idle       = idle_o;
    @(posedge clk_i);
    if (pop) void'(m_q.pop_front());
    if (m_busy && mem_cmd_yumi_i) begin
      m_q.push_back(m_tag);
      m_busy = 1'b0;
    end
    if (grant) begin
      m_busy = 1'b1;
      m_tag  = g;
      m_cmd  = cmd_data[g];
      m_ptr  = (g + 1) % NC;
    end
    m_warm = 1'b1;
    #1;
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear before any edge.
  task automatic do_reset(input string tag);
    #2 reset_i = 1'b1;
    #1;
    chk({tag, "_rst_cmd_v"},  32'(mem_cmd_v_o),       0);
    chk({tag, "_rst_cmd"},    mem_cmd_o,              0);
    chk({tag, "_rst_yumi"},   32'(client_cmd_yumi_o), 0);
    chk({tag, "_rst_idle"},   32'(idle_o),            0);
    chk({tag, "_rst_rready"}, 32'(mem_resp_ready_o),  0);
    chk({tag, "_rst_resp_v"}, 32'(client_resp_v_o),   0);
    model_reset();
    @(posedge clk_i);
    #1 reset_i = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    client_cmd_v_i      = '0;
    mem_cmd_yumi_i      = 1'b1;
    client_resp_ready_i = '1;
    while ((m_q.size() > 0 || m_busy) && guard < 40) begin
      mem_resp_v_i = (m_q.size() > 0);
      mem_resp_i   = $urandom;
      cycle();
      guard++;
    end
    mem_resp_v_i = 1'b0;
    chk("drain_bound", 32'(guard < 40), 1);
  endtask

  function automatic int oh_to_idx(input logic [NC-1:0] oh);
    for (int i = 0; i < NC; i++) if (oh[i]) return i;
    return -1;
  endfunction

  initial begin
    int gq[$];
    int exp_seq[5];
    exp_seq = '{0, 1, 2, 3, 0};

    reset_i             = 1'b1;
    client_cmd_v_i      = '0;
    mem_cmd_yumi_i      = 1'b0;
    mem_resp_v_i        = 1'b0;
    mem_resp_i          = '0;
    client_resp_ready_i = '1;
    for (int i = 0; i < NC; i++) cmd_data[i] = $urandom;
    model_reset();
    #3;
    chk("por_cmd_v",  32'(mem_cmd_v_o),       0);
    chk("por_yumi",   32'(client_cmd_yumi_o), 0);
    chk("por_idle",   32'(idle_o),            0);
    chk("por_cmd",    mem_cmd_o,              0);
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    cycle();  // leaves e_reset

    // Single command from client 2, memory always accepting
    mem_cmd_yumi_i = 1'b1;
    client_cmd_v_i = 4'b0100;
    cycle();
    chk("t1_yumi", 32'(obs_yumi), 32'h4);
    client_cmd_v_i = '0;
    cycle();
    chk("t1_cmd_v", 32'(obs_cmd_v), 1);
    cycle();
    mem_resp_v_i = 1'b1;
    mem_resp_i   = $urandom;
    cycle();
    chk("t1_resp_v", 32'(obs_resp_v), 32'h4);
    mem_resp_v_i = 1'b0;
    cycle();

    // Round-robin fairness from pointer 0
    do_reset("t2");
    cycle();
    client_cmd_v_i = '1;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (obs_yumi != '0) gq.push_back(oh_to_idx(obs_yumi));
    end
    chk("t2_grant_count", gq.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < gq.size()) chk($sformatf("t2_grant%0d", i), gq[i], exp_seq[i]);
    drain();

    // Outstanding limit, grant on the freeing pop, then push with pop at 7
    do_reset("t3");
    cycle();
    client_cmd_v_i = '1;
    for (int c = 0; c < 16; c++) cycle();
    cycle();
    chk("t3_blocked_yumi", 32'(obs_yumi), 0);
    chk("t3_blocked_idle", 32'(obs_idle), 0);
    mem_resp_v_i = 1'b1;
    cycle();
    chk("t3_grant_on_pop", 32'(obs_yumi), 32'h1);
    mem_resp_v_i = 1'b0;
    cycle();
    mem_resp_v_i = 1'b1;
    cycle();
    cycle();  // push and pop together
    mem_resp_v_i = 1'b0;
    drain();

    // Response backpressure for client 1
    do_reset("t4");
    cycle();
    client_cmd_v_i = 4'b0010;
    cycle();
    client_cmd_v_i = '0;
    cycle();
    client_resp_ready_i = 4'b1101;
    mem_resp_v_i        = 1'b1;
    cycle();
    chk("t4_bp_ready", 32'(obs_resp_ready), 0);
    chk("t4_bp_resp_v", 32'(obs_resp_v), 32'h2);
    cycle();
    client_resp_ready_i = '1;
    cycle();
    chk("t4_release_ready", 32'(obs_resp_ready), 1);
    mem_resp_v_i = 1'b0;
    cycle();
    chk("t4_idle", 32'(obs_idle), 1);

    // Reset while sending with three outstanding
    client_cmd_v_i = '1;
    for (int c = 0; c < 6; c++) cycle();
    mem_cmd_yumi_i = 1'b0;
    cycle();
    cycle();
    chk("t5_in_send", 32'(obs_cmd_v), 1);
    do_reset("t5");
    mem_cmd_yumi_i = 1'b1;
    cycle();
    cycle();
    chk("t5_idle_after", 32'(obs_idle), 1);
    chk("t5_ptr_zero", 32'(obs_yumi), 32'h1);
    drain();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NC; i++) cmd_data[i] = $urandom;
      client_cmd_v_i      = NC'($urandom);
      mem_cmd_yumi_i      = ($urandom_range(0, 3) != 0);
      mem_resp_v_i        = (m_q.size() > 0) && ($urandom_range(0, 2) == 0);
      mem_resp_i          = $urandom;
      client_resp_ready_i = NC'($urandom) | NC'($urandom);
      cycle();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
